// File: rtl/mii_pkg.sv
// Shared definitions for the MII receive front end: FSM encoding, framing and
// CRC constants, and the bit layout of the per-frame status vector.
package mii_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPreamble,
        StData,
        StDiscard
    } rx_state_e;

    localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
    localparam logic [3:0]  SFD_NIB      = 4'hD;

    localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
    // Residue is quoted MSB-first; the shift register holds it bit-reversed.
    localparam logic [31:0] CRC_RESIDUE  = 32'hC704DD7B;
    localparam logic [31:0] CRC_POLY     = 32'hEDB88320;

    localparam int unsigned STAT_W       = 27;
    localparam int unsigned STAT_CNT_LSB = 0;
    localparam int unsigned STAT_CNT_MSB = 15;
    localparam int unsigned STAT_CRC_OK  = 16;
    localparam int unsigned STAT_DRIBBLE = 17;
    localparam int unsigned STAT_RX_ERR  = 18;
    localparam int unsigned STAT_BCAST   = 19;
    localparam int unsigned STAT_MCAST   = 20;
    localparam int unsigned STAT_SHORT   = 21;
    localparam int unsigned STAT_LONG    = 22;

    function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_nibble.sv
// Combinational next-state of the reflected IEEE 802.3 CRC-32 for one nibble.
// The nibble is consumed LSB first, matching MII low-bit-first ordering.
module crc32_nibble
    import mii_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [3:0]  nib_i,
    output logic [31:0] crc_o
);

    // Four right-shift steps of the reflected LFSR
    always_comb begin
        logic [31:0] c;
        c = crc_i ^ {28'h0, nib_i};
        for (int i = 0; i < 4; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/mii_rx_nibble_assembler.sv
// MII receive front end: strips preamble/SFD, packs nibbles into bytes with a
// one-byte holdback so the final FCS byte can be flagged, checks FCS and length,
// and emits one status vector per frame.
module mii_rx_nibble_assembler
    import mii_pkg::*;
#(
    parameter int unsigned MAX_FRAME = 1518,
    parameter int unsigned MIN_FRAME = 64
) (
    input  logic              phy_rx_clk,
    input  logic              reset,
    input  logic              phy_rx_dv,
    input  logic [3:0]        phy_rxd,
    input  logic              phy_rx_err,
    output logic [7:0]        rx_mac_data,
    output logic              rx_mac_valid,
    output logic              rx_mac_last,
    output logic              rx_stat_valid,
    output logic [STAT_W-1:0] rx_stat_vector
);

    rx_state_e state_q, state_d;

    // Decoded per-cycle events
    logic sfd_hit;
    logic nib_take;
    logic byte_done;
    logic frame_end;

    // Datapath state
    logic              hi_phase_q;
    logic [3:0]        lo_nib_q;
    logic [31:0]       crc_q;
    logic [31:0]       crc_mid_q;
    logic [31:0]       crc_nxt;
    logic [7:0]        pend_q;
    logic              pend_vld_q;
    logic [15:0]       byte_cnt_q;
    logic              err_q;
    logic              mcast_q;
    logic              bcast_q;
    logic              end_q;
    logic              stat_arm_q;
    logic [STAT_W-1:0] stat_hold_q;
    logic [STAT_W-1:0] stat_d;
    logic [7:0]        byte_new;

    logic [7:0]        data_q;
    logic              valid_q;
    logic              last_q;
    logic              stat_valid_q;
    logic [STAT_W-1:0] stat_vec_q;

    // State register
    always_ff @(posedge phy_rx_clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (phy_rx_dv) state_d = StPreamble;
            end
            StPreamble: begin
                if (!phy_rx_dv) begin
                    state_d = StIdle;
                end else if (phy_rxd == SFD_NIB) begin
                    state_d = StData;
                end else if (phy_rxd != PREAMBLE_NIB) begin
                    state_d = StDiscard;
                end
            end
            StData: begin
                if (!phy_rx_dv) state_d = StIdle;
            end
            StDiscard: begin
                if (!phy_rx_dv) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: per-cycle datapath events
    always_comb begin
        sfd_hit   = (state_q == StPreamble) && phy_rx_dv && (phy_rxd == SFD_NIB);
        nib_take  = (state_q == StData) && phy_rx_dv;
        byte_done = nib_take && hi_phase_q;
        frame_end = (state_q == StData) && !phy_rx_dv;
    end

    // High nibble continues from the CRC snapshot taken after the low nibble
    crc32_nibble u_crc (
        .crc_i (hi_phase_q ? crc_mid_q : crc_q),
        .nib_i (phy_rxd),
        .crc_o (crc_nxt)
    );

    assign byte_new = {phy_rxd, lo_nib_q};

    // Status vector assembled from the flags as they stand when dv drops
    always_comb begin
        stat_d                            = '0;
        stat_d[STAT_CNT_MSB:STAT_CNT_LSB] = byte_cnt_q;
        stat_d[STAT_CRC_OK]               = (bit_reverse32(crc_q) == CRC_RESIDUE);
        stat_d[STAT_DRIBBLE]              = hi_phase_q;
        stat_d[STAT_RX_ERR]               = err_q;
        stat_d[STAT_BCAST]                = bcast_q && (byte_cnt_q >= 16'd6);
        stat_d[STAT_MCAST]                = mcast_q;
        stat_d[STAT_SHORT]                = (32'(byte_cnt_q) < MIN_FRAME);
        stat_d[STAT_LONG]                 = (32'(byte_cnt_q) > MAX_FRAME);
    end

    // Byte assembly, holdback, CRC, counters and output strobes
    always_ff @(posedge phy_rx_clk) begin
        if (!reset) begin
            hi_phase_q   <= 1'b0;
            lo_nib_q     <= '0;
            crc_q        <= CRC_INIT;
            crc_mid_q    <= CRC_INIT;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            byte_cnt_q   <= '0;
            err_q        <= 1'b0;
            mcast_q      <= 1'b0;
            bcast_q      <= 1'b0;
            end_q        <= 1'b0;
            stat_arm_q   <= 1'b0;
            stat_hold_q  <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            stat_valid_q <= 1'b0;
            stat_vec_q   <= '0;
        end else begin
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            stat_valid_q <= 1'b0;

            if (sfd_hit) begin
                hi_phase_q <= 1'b0;
                crc_q      <= CRC_INIT;
                pend_vld_q <= 1'b0;
                byte_cnt_q <= '0;
                err_q      <= 1'b0;
                mcast_q    <= 1'b0;
                bcast_q    <= 1'b1;
            end

            if (nib_take) begin
                err_q <= err_q | phy_rx_err;
                if (!hi_phase_q) begin
                    lo_nib_q   <= phy_rxd;
                    crc_mid_q  <= crc_nxt;
                    hi_phase_q <= 1'b1;
                end else begin
                    hi_phase_q <= 1'b0;
                    crc_q      <= crc_nxt;
                end
            end

            if (byte_done) begin
                pend_q     <= byte_new;
                pend_vld_q <= 1'b1;
                if (pend_vld_q) begin
                    data_q  <= pend_q;
                    valid_q <= 1'b1;
                end
                if (byte_cnt_q != 16'hFFFF) byte_cnt_q <= byte_cnt_q + 16'd1;
                if (byte_cnt_q == 16'd0) mcast_q <= lo_nib_q[0];
                if ((byte_cnt_q < 16'd6) && (byte_new != 8'hFF)) bcast_q <= 1'b0;
            end

            // Frames with no complete byte leave no trace on the outputs
            if (frame_end) begin
                hi_phase_q <= 1'b0;
                pend_vld_q <= 1'b0;
                if (pend_vld_q) begin
                    end_q       <= 1'b1;
                    stat_hold_q <= stat_d;
                end
            end

            // Last byte is pushed one cycle later so valid never runs back to back
            if (end_q) begin
                end_q      <= 1'b0;
                data_q     <= pend_q;
                valid_q    <= 1'b1;
                last_q     <= 1'b1;
                stat_arm_q <= 1'b1;
            end

            if (stat_arm_q) begin
                stat_arm_q   <= 1'b0;
                stat_valid_q <= 1'b1;
                stat_vec_q   <= stat_hold_q;
            end
        end
    end

    assign rx_mac_data    = data_q;
    assign rx_mac_valid   = valid_q;
    assign rx_mac_last    = last_q;
    assign rx_stat_valid  = stat_valid_q;
    assign rx_stat_vector = stat_vec_q;

endmodule

// File: tb/tb_mii_rx_nibble_assembler.sv
// Self-checking bench: frames are built as byte lists, driven as MII nibbles,
// and the received byte stream / status vectors are compared to a frame-level
// reference model (CRC over bytes, length and address rules).
module tb_mii_rx_nibble_assembler;

    logic        phy_rx_clk = 1'b0;
    logic        reset;
    logic        phy_rx_dv;
    logic [3:0]  phy_rxd;
    logic        phy_rx_err;
    logic [7:0]  rx_mac_data;
    logic        rx_mac_valid;
    logic        rx_mac_last;
    logic        rx_stat_valid;
    logic [26:0] rx_stat_vector;

    int checks   = 0;
    int failures = 0;

    always #5 phy_rx_clk = ~phy_rx_clk;

    mii_rx_nibble_assembler #(
        .MAX_FRAME (1518),
        .MIN_FRAME (64)
    ) dut (
        .phy_rx_clk     (phy_rx_clk),
        .reset          (reset),
        .phy_rx_dv      (phy_rx_dv),
        .phy_rxd        (phy_rxd),
        .phy_rx_err     (phy_rx_err),
        .rx_mac_data    (rx_mac_data),
        .rx_mac_valid   (rx_mac_valid),
        .rx_mac_last    (rx_mac_last),
        .rx_stat_valid  (rx_stat_valid),
        .rx_stat_vector (rx_stat_vector)
    );

    logic [7:0]  tx_q[$];
    logic [7:0]  exp_bytes[$];
    int          exp_last[$];
    logic [26:0] exp_stat[$];
    logic [7:0]  got_bytes[$];
    int          got_last[$];
    logic [26:0] got_stat[$];

    int   cyc          = 0;
    int   last_cyc     = -100;
    int   b2b_cnt      = 0;
    int   stat_gap_bad = 0;
    int   stray_last   = 0;
    logic prev_valid   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge
    always @(negedge phy_rx_clk) begin
        cyc++;
        if (rx_mac_valid) begin
            got_bytes.push_back(rx_mac_data);
            if (rx_mac_last) begin
                got_last.push_back(got_bytes.size());
                last_cyc = cyc;
            end
        end
        if (rx_mac_last && !rx_mac_valid) stray_last++;
        if (rx_mac_valid && prev_valid) b2b_cnt++;
        prev_valid = rx_mac_valid;
        if (rx_stat_valid) begin
            got_stat.push_back(rx_stat_vector);
            if (cyc - last_cyc != 1) stat_gap_bad++;
        end
    end

    function automatic logic [31:0] fcs_of(input int len);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
            c = c ^ {24'h0, tx_q[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic append_fcs();
        logic [31:0] c = fcs_of(tx_q.size());
        tx_q.push_back(c[7:0]);
        tx_q.push_back(c[15:8]);
        tx_q.push_back(c[23:16]);
        tx_q.push_back(c[31:24]);
    endtask

    task automatic build(input logic [47:0] da, input int plen, input logic [7:0] fill,
                         input bit rnd);
        logic [47:0] sa = 48'h59abcdef1122;
        tx_q = {};
        for (int i = 5; i >= 0; i--) tx_q.push_back(da[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) tx_q.push_back(sa[i*8 +: 8]);
        tx_q.push_back(8'hab);
        tx_q.push_back(8'h12);
        for (int i = 0; i < plen; i++) tx_q.push_back(rnd ? 8'($urandom) : fill);
        append_fcs();
    endtask

    // Reference model: what a correct receiver reports for the frame in tx_q
    task automatic expect_frame(input bit odd, input bit err);
        int          n  = tx_q.size();
        bit          bc = (n >= 6);
        logic [31:0] rx_fcs;
        logic [26:0] v;
        foreach (tx_q[i]) exp_bytes.push_back(tx_q[i]);
        exp_last.push_back(exp_bytes.size());
        rx_fcs = {tx_q[n-1], tx_q[n-2], tx_q[n-3], tx_q[n-4]};
        for (int i = 0; i < 6 && i < n; i++) if (tx_q[i] != 8'hFF) bc = 1'b0;
        v       = '0;
        v[15:0] = (n > 65535) ? 16'hFFFF : n[15:0];
        v[16]   = (fcs_of(n - 4) == rx_fcs);
        v[17]   = odd;
        v[18]   = err;
        v[19]   = bc;
        v[20]   = tx_q[0][0];
        v[21]   = (n < 64);
        v[22]   = (n > 1518);
        exp_stat.push_back(v);
    endtask

    task automatic nib(input logic [3:0] d, input logic e);
        phy_rx_dv  = 1'b1;
        phy_rxd    = d;
        phy_rx_err = e;
        @(negedge phy_rx_clk);
    endtask

    task automatic idle(input int k);
        phy_rx_dv  = 1'b0;
        phy_rxd    = 4'h0;
        phy_rx_err = 1'b0;
        repeat (k) @(negedge phy_rx_clk);
    endtask

    // Drives tx_q; trunc>0 stops after that many bytes and pulses reset instead
    task automatic drive_frame(input bit odd, input int err_idx, input bit bad_pre,
                               input int gap, input int trunc);
        int nb = (trunc > 0) ? trunc : tx_q.size();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) nib(4'hD, 1'b0);
            else if (bad_pre && i == 6) nib(4'h3, 1'b0);
            else nib(4'h5, 1'b0);
        end
        for (int i = 0; i < nb; i++) begin
            nib(tx_q[i][3:0], (i == err_idx));
            nib(tx_q[i][7:4], 1'b0);
        end
        if (trunc > 0) begin
            reset     = 1'b0;
            phy_rx_dv = 1'b0;
            phy_rxd   = 4'h0;
            @(negedge phy_rx_clk);
            check_eq("trunc_rst_valid", {31'h0, rx_mac_valid}, 32'h0);
            check_eq("trunc_rst_data", {24'h0, rx_mac_data}, 32'h0);
            @(negedge phy_rx_clk);
            reset = 1'b1;
            idle(gap);
        end else begin
            if (odd) nib(4'($urandom), 1'b0);
            idle(gap);
        end
    endtask

    task automatic finish_check(input string tag);
        int mism = 0;
        int lm   = 0;
        int sm   = 0;
        idle(8);
        check_eq({tag, "_nbytes"}, got_bytes.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++)
            if (got_bytes[i] !== exp_bytes[i]) mism++;
        check_eq({tag, "_data_mism"}, mism, 0);
        check_eq({tag, "_nlast"}, got_last.size(), exp_last.size());
        for (int i = 0; i < exp_last.size() && i < got_last.size(); i++)
            if (got_last[i] != exp_last[i]) lm++;
        check_eq({tag, "_last_pos_mism"}, lm, 0);
        check_eq({tag, "_nstat"}, got_stat.size(), exp_stat.size());
        for (int i = 0; i < exp_stat.size() && i < got_stat.size(); i++) begin
            if (got_stat[i] !== exp_stat[i]) begin
                sm++;
                $display("FAIL %s_stat%0d got=0x%0h expected=0x%0h", tag, i, got_stat[i],
                         exp_stat[i]);
            end
        end
        check_eq({tag, "_stat_mism"}, sm, 0);
        check_eq({tag, "_valid_b2b"}, b2b_cnt, 0);
        check_eq({tag, "_stat_gap"}, stat_gap_bad, 0);
        check_eq({tag, "_stray_last"}, stray_last, 0);
        got_bytes = {};
        got_last  = {};
        got_stat  = {};
        exp_bytes = {};
        exp_last  = {};
        exp_stat  = {};
        b2b_cnt      = 0;
        stat_gap_bad = 0;
        stray_last   = 0;
    endtask

    initial begin
        reset      = 1'b0;
        phy_rx_dv  = 1'b0;
        phy_rxd    = 4'h0;
        phy_rx_err = 1'b0;
        repeat (3) @(negedge phy_rx_clk);
        check_eq("rst_valid", {31'h0, rx_mac_valid}, 32'h0);
        check_eq("rst_last", {31'h0, rx_mac_last}, 32'h0);
        check_eq("rst_stat_valid", {31'h0, rx_stat_valid}, 32'h0);
        check_eq("rst_stat_vec", {5'h0, rx_stat_vector}, 32'h0);
        check_eq("rst_data", {24'h0, rx_mac_data}, 32'h0);
        reset = 1'b1;
        idle(2);

        // Unicast 118-byte frame with good FCS
        build(48'h12d146111011, 100, 8'h19, 1'b0);
        expect_frame(1'b0, 1'b0);
        drive_frame(1'b0, -1, 1'b0, 4, 0);
        check_eq("uni_first_byte", {24'h0, got_bytes[0]}, 32'h12);
        check_eq("uni_crc_ok", {31'h0, got_stat.size() > 0 ? got_stat[0][16] : 1'b0}, 32'h1);
        finish_check("unicast");

        // Same frame with one payload nibble flipped after the FCS was computed
        build(48'h12d146111011, 100, 8'h19, 1'b0);
        tx_q[30] = tx_q[30] ^ 8'h04;
        expect_frame(1'b0, 1'b0);
        drive_frame(1'b0, -1, 1'b0, 4, 0);
        finish_check("badcrc");

        // Broadcast minimum-length frame
        build(48'hffffffffffff, 46, 8'h00, 1'b1);
        expect_frame(1'b0, 1'b0);
        drive_frame(1'b0, -1, 1'b0, 4, 0);
        finish_check("bcast");

        // 60-byte frame with a trailing odd nibble
        build(48'h021122334455, 42, 8'h00, 1'b1);
        expect_frame(1'b1, 1'b0);
        drive_frame(1'b1, -1, 1'b0, 4, 0);
        finish_check("dribble");

        // Corrupt preamble: nothing at all comes out
        build(48'h12d146111011, 50, 8'h33, 1'b0);
        drive_frame(1'b0, -1, 1'b1, 4, 0);
        finish_check("badpre");

        // Reset after 20 data bytes, then a clean frame
        build(48'h12d146111011, 100, 8'h19, 1'b1);
        for (int i = 0; i < 19; i++) exp_bytes.push_back(tx_q[i]);
        drive_frame(1'b0, -1, 1'b0, 3, 20);
        finish_check("trunc");
        build(48'h0a0b0c0d0e0f, 60, 8'h00, 1'b1);
        expect_frame(1'b0, 1'b0);
        drive_frame(1'b0, -1, 1'b0, 4, 0);
        finish_check("post_trunc");

        // rx_err pulse mid-frame
        build(48'h12d146111011, 80, 8'h00, 1'b1);
        expect_frame(1'b0, 1'b1);
        drive_frame(1'b0, 40, 1'b0, 4, 0);
        finish_check("rxerr");

        // Oversized frame
        build(48'h12d146111011, 1510, 8'h00, 1'b1);
        expect_frame(1'b0, 1'b0);
        drive_frame(1'b0, -1, 1'b0, 4, 0);
        finish_check("toolong");

        // Back-to-back frames with dv rising right after the previous frame ends
        build(48'h12d146111011, 50, 8'h00, 1'b1);
        expect_frame(1'b0, 1'b0);
        drive_frame(1'b0, -1, 1'b0, 1, 0);
        build(48'hffffffffffff, 46, 8'h00, 1'b1);
        expect_frame(1'b0, 1'b0);
        drive_frame(1'b0, -1, 1'b0, 4, 0);
        finish_check("b2b");

        // Randomized frames
        for (int f = 0; f < 12; f++) begin
            logic [47:0] da;
            int          plen = int'($urandom_range(20, 120));
            bit          odd  = ($urandom_range(0, 3) == 0);
            bit          flip = ($urandom_range(0, 2) == 0);
            int          eidx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1;
            da = ($urandom_range(0, 2) == 0) ? 48'hffffffffffff : {16'($urandom), 32'($urandom)};
            build(da, plen, 8'h00, 1'b1);
            if (flip) tx_q[15] = tx_q[15] ^ 8'h80;
            expect_frame(odd, eidx >= 0);
            drive_frame(odd, eidx, 1'b0, int'($urandom_range(1, 4)), 0);
        end
        finish_check("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
